chip8_vram_arbiter: RTL and testbench

CHIP8_VRAM_ARBITER -- requirements
Module: chip8_vram_arbiter

---
 rtl/chip8_vram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_chip8_vram_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_vram_arbiter.sv
// -----------------------------------------------------------------------------
// chip8_vram_arbiter
//
// Two-requester arbiter in front of a single-port VRAM block RAM for a CHIP-8
// display (64x32 pixels, 8 bytes per row). Requester A is the sprite/clear
// engine and requester B is the buffer copy/scan-out path.
//
// Arbitration is round-robin between A and B. A requester can ask for an
// atomic grant (x_lock_in) so that a read-modify-write sequence is not
// interleaved with the other requester. Reads are fully pipelined. A shift
// register READ_LATENCY deep tracks which port issued each read, so the
// returning BRAM data is routed back to that port.
//
// Parameters
//   ADDR_WIDTH   : VRAM byte address width
//   DATA_WIDTH   : VRAM word width
//   READ_LATENCY : cycles from an accepted read to BRAM data valid (1..4)
//
// Ports
//   clk_in, rst_n_in          : clock, asynchronous active-low reset
//   a_valid_in / a_ready_out  : requester A handshake
//   a_we_in, a_lock_in        : A write select, A atomic-grant request
//   a_addr_in, a_data_in      : A address, A write data
//   a_rvalid_out, a_rdata_out : A read return (data forced to 0 when idle)
//   b_*                       : same set of signals for requester B
//   mem_en_out, mem_we_out    : BRAM enable / write enable
//   mem_addr_out, mem_data_out: BRAM address / write data
//   mem_data_in               : BRAM read data, READ_LATENCY cycles after read
// -----------------------------------------------------------------------------
module chip8_vram_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  a_valid_in,
    output logic                  a_ready_out,
    input  logic                  a_we_in,
    input  logic                  a_lock_in,
    input  logic [ADDR_WIDTH-1:0] a_addr_in,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    output logic                  a_rvalid_out,
    output logic [DATA_WIDTH-1:0] a_rdata_out,
    input  logic                  b_valid_in,
    output logic                  b_ready_out,
    input  logic                  b_we_in,
    input  logic                  b_lock_in,
    input  logic [ADDR_WIDTH-1:0] b_addr_in,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    output logic                  b_rvalid_out,
    output logic [DATA_WIDTH-1:0] b_rdata_out,
    output logic                  mem_en_out,
    output logic                  mem_we_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in
);

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_last_grant_b;   // 1: B won the last open handshake
    logic [READ_LATENCY-1:0] r_pipe_vld;       // read in flight at each stage
    logic [READ_LATENCY-1:0] r_pipe_own_b;     // 1: that read belongs to B

    logic w_grant_a;
    logic w_grant_b;
    logic w_hs_a;
    logic w_hs_b;
    logic w_issue_rd;

    // Grant selection. Ready only goes high for a requester that is valid, so
    // ready doubles as the handshake indication.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        case (r_state)
            ST_OPEN: begin
                if (a_valid_in && b_valid_in) begin
                    // Tie: the requester that did not win last time goes first.
                    w_grant_a = r_last_grant_b;
                    w_grant_b = ~r_last_grant_b;
                end else begin
                    w_grant_a = a_valid_in;
                    w_grant_b = b_valid_in;
                end
            end
            ST_LOCK_A: w_grant_a = a_valid_in;
            ST_LOCK_B: w_grant_b = b_valid_in;
            default: begin
                w_grant_a = 1'b0;
                w_grant_b = 1'b0;
            end
        endcase
    end

    // The reset term keeps every request blocked while reset is held, even if
    // a requester keeps valid asserted through reset.
    assign w_hs_a      = w_grant_a & rst_n_in;
    assign w_hs_b      = w_grant_b & rst_n_in;
    assign a_ready_out = w_hs_a;
    assign b_ready_out = w_hs_b;

    assign mem_en_out   = w_hs_a | w_hs_b;
    assign mem_we_out   = w_hs_a ? a_we_in   : (w_hs_b ? b_we_in   : 1'b0);
    assign mem_addr_out = w_hs_a ? a_addr_in : (w_hs_b ? b_addr_in : '0);
    assign mem_data_out = w_hs_a ? a_data_in : (w_hs_b ? b_data_in : '0);
    assign w_issue_rd   = mem_en_out & ~mem_we_out;

    // Arbitration state and last-grant memory.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= ST_OPEN;
            r_last_grant_b <= 1'b1;          // A wins the first tie after reset
        end else begin
            case (r_state)
                ST_OPEN: begin
                    if (w_hs_a) begin
                        r_last_grant_b <= 1'b0;
                        if (a_lock_in) r_state <= ST_LOCK_A;
                    end else if (w_hs_b) begin
                        r_last_grant_b <= 1'b1;
                        if (b_lock_in) r_state <= ST_LOCK_B;
                    end
                end
                // A dropped lock releases the bus even without a request; a
                // handshake in that same cycle has already been served above.
                ST_LOCK_A: if (!a_lock_in) r_state <= ST_OPEN;
                ST_LOCK_B: if (!b_lock_in) r_state <= ST_OPEN;
                default:   r_state <= ST_OPEN;
            endcase
        end
    end

    // Read return pipeline. Stage 0 is loaded at the edge that accepts the
    // read, so the last stage is valid exactly READ_LATENCY cycles after the
    // handshake, which is when the BRAM data arrives.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pipe_vld   <= '0;
            r_pipe_own_b <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_pipe_vld[i]   <= r_pipe_vld[i-1];
                r_pipe_own_b[i] <= r_pipe_own_b[i-1];
            end
            r_pipe_vld[0]   <= w_issue_rd;
            r_pipe_own_b[0] <= w_hs_b;
        end
    end

    assign a_rvalid_out = r_pipe_vld[READ_LATENCY-1] & ~r_pipe_own_b[READ_LATENCY-1];
    assign b_rvalid_out = r_pipe_vld[READ_LATENCY-1] &  r_pipe_own_b[READ_LATENCY-1];
    assign a_rdata_out  = a_rvalid_out ? mem_data_in : '0;
    assign b_rdata_out  = b_rvalid_out ? mem_data_in : '0;

endmodule

// File: tb/tb_chip8_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_chip8_vram_arbiter
//
// Directed bench for chip8_vram_arbiter. The main instance (u_dut) uses
// READ_LATENCY=2 and runs a table of per-cycle vectors covering round-robin
// ties, lock, and read-after-write. It is followed by hand-written sequences
// for idle, reset during an in-flight read, and a second instance (u_dut3)
// with READ_LATENCY=3. Each instance is backed by a small BRAM model whose
// read latency matches that instance.
// -----------------------------------------------------------------------------
module tb_chip8_vram_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- main DUT (READ_LATENCY = 2) ----------------
    logic       a_valid, a_ready, a_we, a_lock, a_rvalid;
    logic [7:0] a_addr, a_data, a_rdata;
    logic       b_valid, b_ready, b_we, b_lock, b_rvalid;
    logic [7:0] b_addr, b_data, b_rdata;
    logic       m_en, m_we;
    logic [7:0] m_addr, m_wdata, m_rdata;

    chip8_vram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(2)) u_dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .a_valid_in(a_valid), .a_ready_out(a_ready), .a_we_in(a_we), .a_lock_in(a_lock),
        .a_addr_in(a_addr), .a_data_in(a_data), .a_rvalid_out(a_rvalid), .a_rdata_out(a_rdata),
        .b_valid_in(b_valid), .b_ready_out(b_ready), .b_we_in(b_we), .b_lock_in(b_lock),
        .b_addr_in(b_addr), .b_data_in(b_data), .b_rvalid_out(b_rvalid), .b_rdata_out(b_rdata),
        .mem_en_out(m_en), .mem_we_out(m_we), .mem_addr_out(m_addr),
        .mem_data_out(m_wdata), .mem_data_in(m_rdata)
    );

    // ---------------- second DUT (READ_LATENCY = 3) ----------------
    logic       l_a_valid, l_a_ready, l_a_we, l_a_lock, l_a_rvalid;
    logic [7:0] l_a_addr, l_a_data, l_a_rdata;
    logic       l_b_valid, l_b_ready, l_b_we, l_b_lock, l_b_rvalid;
    logic [7:0] l_b_addr, l_b_data, l_b_rdata;
    logic       l_en, l_we;
    logic [7:0] l_addr, l_wdata, l_rdata;

    chip8_vram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(3)) u_dut3 (
        .clk_in(clk), .rst_n_in(rst_n),
        .a_valid_in(l_a_valid), .a_ready_out(l_a_ready), .a_we_in(l_a_we), .a_lock_in(l_a_lock),
        .a_addr_in(l_a_addr), .a_data_in(l_a_data), .a_rvalid_out(l_a_rvalid), .a_rdata_out(l_a_rdata),
        .b_valid_in(l_b_valid), .b_ready_out(l_b_ready), .b_we_in(l_b_we), .b_lock_in(l_b_lock),
        .b_addr_in(l_b_addr), .b_data_in(l_b_data), .b_rvalid_out(l_b_rvalid), .b_rdata_out(l_b_rdata),
        .mem_en_out(l_en), .mem_we_out(l_we), .mem_addr_out(l_addr),
        .mem_data_out(l_wdata), .mem_data_in(l_rdata)
    );

    // ---------------- BRAM models ----------------
    function automatic logic [7:0] init_val(input logic [7:0] addr);
        case (addr)
            8'h10:   init_val = 8'h11;
            8'h20:   init_val = 8'h22;
            8'h05:   init_val = 8'h55;
            8'h7F:   init_val = 8'hA5;
            default: init_val = addr ^ 8'hC3;
        endcase
    endfunction

    logic [7:0] mem2 [256];
    logic [7:0] pipe2 [2];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem2[i] <= init_val(8'(i));
        end else if (m_en && m_we) begin
            mem2[m_addr] <= m_wdata;
        end
        pipe2[0] <= mem2[m_addr];
        pipe2[1] <= pipe2[0];
    end
    assign m_rdata = pipe2[1];

    logic [7:0] mem3 [256];
    logic [7:0] pipe3 [3];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_val(8'(i));
        end else if (l_en && l_we) begin
            mem3[l_addr] <= l_wdata;
        end
        pipe3[0] <= mem3[l_addr];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign l_rdata = pipe3[2];

    // ---------------- checking helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       av, awe, alk;
        logic [7:0] aaddr, adata;
        logic       bv, bwe, blk;
        logic [7:0] baddr, bdata;
        logic       e_ardy, e_brdy, e_en, e_we;
        logic [7:0] e_addr, e_data;
        logic       e_arv;
        logic [7:0] e_ard;
        logic       e_brv;
        logic [7:0] e_brd;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    task automatic drive(input vec_t v);
        a_valid = v.av; a_we = v.awe; a_lock = v.alk; a_addr = v.aaddr; a_data = v.adata;
        b_valid = v.bv; b_we = v.bwe; b_lock = v.blk; b_addr = v.baddr; b_data = v.bdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Inputs: av awe alk aaddr adata | bv bwe blk baddr bdata
        // Expect: a_rdy b_rdy en we addr data | a_rv a_rd | b_rv b_rd
        // Tie from reset: alternate A,B; reads return two cycles later.
        tbl[0]  = '{1'b1,1'b0,1'b0,8'h10,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h10,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tbl[1]  = '{1'b1,1'b0,1'b0,8'h10,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h20,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tbl[2]  = '{1'b1,1'b0,1'b0,8'h10,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h10,8'h00, 1'b1,8'h11, 1'b0,8'h00};
        tbl[3]  = '{1'b1,1'b0,1'b0,8'h10,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h20,8'h00, 1'b0,8'h00, 1'b1,8'h22};
        tbl[4]  = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'h11, 1'b0,8'h00};
        tbl[5]  = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, 1'b1,8'h22};
        tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        // Lock: A locked read of 0x05, B held off, A write with lock dropped, then B.
        tbl[7]  = '{1'b1,1'b0,1'b1,8'h05,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h05,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tbl[8]  = '{1'b0,1'b0,1'b1,8'h05,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tbl[9]  = '{1'b1,1'b1,1'b0,8'h05,8'h99, 1'b1,1'b0,1'b0,8'h20,8'h00, 1'b1,1'b0,1'b1,1'b1,8'h05,8'h99, 1'b1,8'h55, 1'b0,8'h00};
        tbl[10] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h05,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h05,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tbl[11] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tbl[12] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, 1'b1,8'h99};
        // Read-after-write: A writes 0x3C to 0x00 then reads it back.
        tbl[13] = '{1'b1,1'b1,1'b0,8'h00,8'h3C, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b1,8'h00,8'h3C, 1'b0,8'h00, 1'b0,8'h00};
        tbl[14] = '{1'b1,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h00,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tbl[15] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, 1'b0,8'h00};
        tbl[16] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'h3C, 1'b0,8'h00};
        tbl[17] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00, 1'b0,8'h00};

        // Second instance stays idle except for its own latency sequence.
        l_a_valid = 1'b0; l_a_we = 1'b0; l_a_lock = 1'b0; l_a_addr = 8'h00; l_a_data = 8'h00;
        l_b_valid = 1'b0; l_b_we = 1'b0; l_b_lock = 1'b0; l_b_addr = 8'h00; l_b_data = 8'h00;

        // Reset with both requesters valid: everything must stay quiet.
        rst_n = 1'b0;
        drive(tbl[0]);
        @(negedge clk);
        chk1("reset a_ready", a_ready, 1'b0);
        chk1("reset b_ready", b_ready, 1'b0);
        chk1("reset mem_en", m_en, 1'b0);
        chk1("reset mem_we", m_we, 1'b0);
        chk1("reset a_rvalid", a_rvalid, 1'b0);
        chk8("reset a_rdata", a_rdata, 8'h00);
        chk1("reset b_rvalid", b_rvalid, 1'b0);
        $display("reset: a_rdy=%0b b_rdy=%0b en=%0b", a_ready, b_ready, m_en);
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk1($sformatf("v%0d a_ready", i), a_ready, tbl[i].e_ardy);
            chk1($sformatf("v%0d b_ready", i), b_ready, tbl[i].e_brdy);
            chk1($sformatf("v%0d mem_en", i), m_en, tbl[i].e_en);
            chk1($sformatf("v%0d mem_we", i), m_we, tbl[i].e_we);
            if (tbl[i].e_en) begin
                chk8($sformatf("v%0d mem_addr", i), m_addr, tbl[i].e_addr);
                chk8($sformatf("v%0d mem_data", i), m_wdata, tbl[i].e_data);
            end
            chk1($sformatf("v%0d a_rvalid", i), a_rvalid, tbl[i].e_arv);
            chk8($sformatf("v%0d a_rdata", i), a_rdata, tbl[i].e_ard);
            chk1($sformatf("v%0d b_rvalid", i), b_rvalid, tbl[i].e_brv);
            chk8($sformatf("v%0d b_rdata", i), b_rdata, tbl[i].e_brd);
            $display("v%0d: a_rdy=%0b b_rdy=%0b en=%0b we=%0b addr=%02h a_rv=%0b a_rd=%02h b_rv=%0b b_rd=%02h",
                     i, a_ready, b_ready, m_en, m_we, m_addr, a_rvalid, a_rdata, b_rvalid, b_rdata);
            next_cycle();
        end

        // Idle for 10 cycles.
        drive(tbl[6]);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk1($sformatf("idle%0d mem_en", k), m_en, 1'b0);
            chk1($sformatf("idle%0d a_ready", k), a_ready, 1'b0);
            chk1($sformatf("idle%0d b_ready", k), b_ready, 1'b0);
            $display("idle%0d: en=%0b a_rdy=%0b b_rdy=%0b", k, m_en, a_ready, b_ready);
            next_cycle();
        end

        // Still open after idle: a lone B request is accepted.
        b_valid = 1'b1; b_addr = 8'h20;
        @(negedge clk);
        chk1("post-idle b_ready", b_ready, 1'b1);
        $display("post-idle: b_rdy=%0b addr=%02h", b_ready, m_addr);
        next_cycle();
        b_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk1("post-idle b_rvalid", b_rvalid, 1'b1);
        chk8("post-idle b_rdata", b_rdata, 8'h22);
        $display("post-idle return: b_rv=%0b b_rd=%02h", b_rvalid, b_rdata);
        next_cycle();

        // Reset mid-flight: A read accepted, reset for one cycle before data returns.
        a_valid = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 8'h10;
        @(negedge clk);
        chk1("midrst a_ready", a_ready, 1'b1);
        $display("midrst issue: a_rdy=%0b", a_ready);
        next_cycle();
        a_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk1("midrst in-reset a_rvalid", a_rvalid, 1'b0);
        chk1("midrst in-reset mem_en", m_en, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        a_valid = 1'b1; a_addr = 8'h10;
        b_valid = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 8'h20;
        @(negedge clk);
        chk1("midrst tie a_ready", a_ready, 1'b1);
        chk1("midrst tie b_ready", b_ready, 1'b0);
        chk1("midrst a_rvalid", a_rvalid, 1'b0);
        $display("midrst tie: a_rdy=%0b b_rdy=%0b a_rv=%0b", a_ready, b_ready, a_rvalid);
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk1("midrst late a_rvalid", a_rvalid, 1'b0);
        chk1("midrst late b_rvalid", b_rvalid, 1'b0);
        next_cycle();
        next_cycle();

        // READ_LATENCY=3 instance: B reads 0x7F (content 0xA5).
        l_b_valid = 1'b1; l_b_addr = 8'h7F;
        @(negedge clk);
        chk1("lat3 b_ready", l_b_ready, 1'b1);
        chk1("lat3 a_ready", l_a_ready, 1'b0);
        $display("lat3 issue: b_rdy=%0b addr=%02h", l_b_ready, l_addr);
        next_cycle();
        l_b_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk1($sformatf("lat3 c%0d b_rvalid", j), l_b_rvalid, (j == 3));
            chk8($sformatf("lat3 c%0d b_rdata", j), l_b_rdata, (j == 3) ? 8'hA5 : 8'h00);
            chk1($sformatf("lat3 c%0d a_rvalid", j), l_a_rvalid, 1'b0);
            chk8($sformatf("lat3 c%0d a_rdata", j), l_a_rdata, 8'h00);
            $display("lat3 c%0d: b_rv=%0b b_rd=%02h a_rv=%0b", j, l_b_rvalid, l_b_rdata, l_a_rvalid);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
